// File: rtl/jt1943_objbuf.sv
// Double-buffered object line buffer: the drawer fills one bank while the other is shown and erased behind the beam.
// obj_pxl follows the display read by one cen6 period; inputs are never stalled, transparent pixels are dropped.
module jt1943_objbuf #(
  parameter int AW = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen6,
  input  logic          LHBL,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    obj_pxl,
  output logic          busy
);
  localparam int         DEPTH  = 2**AW;
  localparam logic [7:0] TRANSP = 8'hFF;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          r_sel;
  logic          r_last_lhbl;
  logic [AW-1:0] r_rd_cnt;
  logic [7:0]    r_rd_dat;
  logic [7:0]    r_obj_pxl;
  logic          r_ers_vld;
  logic          r_ers_bank;
  logic [AW-1:0] r_ers_addr;
  logic [7:0]    r_mem [2][DEPTH];

  logic          w_clear;
  logic          w_run;
  logic          w_draw_we;
  logic [1:0]    w_we;
  logic [AW-1:0] w_addr [2];
  logic [7:0]    w_dat  [2];
  logic [7:0]    w_rd_dat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && (&r_clr_cnt)) w_state_nxt = ST_RUN;
  end

  always_comb begin
    busy    = (r_state == ST_CLEAR);
    w_clear = (r_state == ST_CLEAR) && !rst;
    w_run   = (r_state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR)  r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // Each bank sees one write per clk: erase only hits the display bank, drawing only the other one.
  always_comb begin
    w_draw_we = w_run && wr_en && (wr_data[3:0] != 4'hF);
    for (int b = 0; b < 2; b++) begin
      w_we[b]   = 1'b0;
      w_addr[b] = r_clr_cnt;
      w_dat[b]  = TRANSP;
      if (w_clear) begin
        w_we[b] = 1'b1;
      end else if (w_run && r_ers_vld && r_ers_bank == 1'(b)) begin
        w_we[b]   = 1'b1;
        w_addr[b] = r_ers_addr;
      end else if (w_draw_we && r_sel != 1'(b)) begin
        w_we[b]   = 1'b1;
        w_addr[b] = wr_addr;
        w_dat[b]  = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (w_we[b]) r_mem[b][w_addr[b]] <= w_dat[b];
    end
  end

  assign w_rd_dat = r_mem[r_sel][r_rd_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= 1'b0;
      r_rd_cnt    <= '0;
      r_last_lhbl <= 1'b0;
      r_rd_dat    <= TRANSP;
      r_obj_pxl   <= TRANSP;
      r_ers_vld   <= 1'b0;
      r_ers_bank  <= 1'b0;
      r_ers_addr  <= '0;
    end else begin
      r_ers_vld <= 1'b0;
      if (w_run && cen6) begin
        r_last_lhbl <= LHBL;
        r_obj_pxl   <= r_last_lhbl ? r_rd_dat : TRANSP;
        if (LHBL) begin
          r_rd_dat   <= w_rd_dat;
          r_rd_cnt   <= r_rd_cnt + 1'b1;
          r_ers_vld  <= 1'b1;
          r_ers_bank <= r_sel;
          r_ers_addr <= r_rd_cnt;
        end else begin
          r_rd_cnt <= '0;
          if (r_last_lhbl) r_sel <= ~r_sel;
        end
      end
    end
  end

  assign obj_pxl = r_obj_pxl;

endmodule

// File: doc/jt1943_objbuf.md
JT1943_OBJBUF -- requirements
Module: jt1943_objbuf

Interface
REQ-001 Parameter AW, default 8: line-buffer address width; one line holds 2**AW pixels.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port clk  input  1  system clock, 24 MHz.
REQ-005 Port cen6  input  1  pixel clock enable, 6 MHz, one clk wide.
REQ-006 Port LHBL  input  1  horizontal blank, active low; high means active line.
REQ-007 Port wr_en  input  1  object drawer pixel write strobe, qualified by clk only.
REQ-008 Port wr_addr  input  AW  horizontal position of the drawn pixel.
REQ-009 Port wr_data  input  8  drawn pixel: [7:6] priority, [5:4] palette, [3:0] colour.
REQ-010 Port obj_pxl  output  8  display pixel to the colour mixer; 8'hFF means transparent.
REQ-011 Port busy  output  1  high while the reset clear sequence runs.

Function
REQ-012 The block SHALL hold two banks of 2**AW x 8 storage: the draw bank and the display bank.
REQ-013 A bank select bit SHALL choose the display bank; the draw bank is always the other bank.
REQ-014 The state machine SHALL have two states: CLEAR and RUN.
REQ-015 In CLEAR, a clear counter SHALL write 8'hFF to address n of both banks in clk cycle n, for n = 0 to 2**AW-1, then enter RUN.
REQ-016 In CLEAR, all writes and reads SHALL be ignored, obj_pxl SHALL be 8'hFF, and busy SHALL be 1.
REQ-017 In RUN, busy SHALL be 0.
REQ-018 In RUN, a wr_en cycle with wr_data[3:0] != 4'hF SHALL write wr_data to draw bank address wr_addr.
REQ-019 In RUN, a wr_en cycle with wr_data[3:0] == 4'hF SHALL leave the buffer unchanged, so transparent pixels never overwrite.
REQ-020 Successive writes to the same address SHALL resolve as last write wins.
REQ-021 Writes SHALL never modify the display bank.
REQ-022 A read counter rd_cnt SHALL be set to 0 on any cen6 with LHBL low.
REQ-023 rd_cnt SHALL increment by 1 on each cen6 with LHBL high, wrapping from 2**AW-1 to 0.
REQ-024 On a cen6 with LHBL high, the block SHALL read display bank address rd_cnt.
REQ-025 obj_pxl SHALL take the read data on the next cen6, giving a latency of one cen6 period.
REQ-026 obj_pxl SHALL load 8'hFF on any cen6 whose previous cen6 had LHBL low.
REQ-027 Read-erase: in the clk cycle after each display read, the block SHALL write 8'hFF to the same display bank address, leaving the bank transparent for its next use as draw bank.
REQ-028 Bank swap: on the first cen6 with LHBL low following a cen6 with LHBL high, the bank select bit SHALL toggle.
REQ-029 A wr_en in the same clk as the swap SHALL target the pre-swap draw bank; later writes SHALL target the new draw bank.
REQ-030 LHBL transitions between cen6 pulses SHALL take effect only at the next cen6.
REQ-031 cen6 SHALL be at most one pulse per 2 clk cycles so the erase slot is always free; the drawer and display sides SHALL use separate storage ports so a write and a read or erase in the same clk never conflict.

Reset
REQ-032 While rst is high, the state SHALL be CLEAR, the clear counter 0, bank select 0, rd_cnt 0, obj_pxl 8'hFF, and busy 1.
REQ-033 Reset asserted mid-line or mid-clear SHALL restart the full clear sequence from address 0 when rst is released.
REQ-034 busy SHALL fall exactly 2**AW clk cycles after rst is released.

Verification
REQ-035 Reset then idle -> busy is high for 256 clk after release; after that, obj_pxl stays 8'hFF through two full lines.
REQ-036 Write 8'h5A at address 10 during line N, then end the line -> during line N+1, obj_pxl is 8'h5A exactly one cen6 after the read of rd_cnt 10; every other position reads 8'hFF.
REQ-037 Write 8'h5A at address 10 during line N, then write 8'h3F at address 10 (transparent) -> line N+1 still shows 8'h5A at address 10; a later write of 8'h21 to the same address in the same line results in 8'h21 being displayed.
REQ-038 Display 8'h5A at address 10 in line N+1, with no writes in line N+1 -> line N+3, which reuses the same bank, shows 8'hFF at address 10 (erase check).
REQ-039 Assert wr_en in the swap clk and one clk later, to different addresses -> the first pixel appears in line N+1 and the second in line N+2.
REQ-040 Pulse rst mid-line with pixels pending -> busy runs 256 clk, bank select returns to 0, and all pending pixels are gone in the following lines.
